// File: rtl/prefetch_pkg.sv
// Shared types and sizing for the prefetch path (Fifo words, decoder bytes).
package prefetch_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [15:0] word_t;

  localparam int unsigned PF_BUF_BYTES = 4;

endpackage

// File: rtl/fifo_byte_reader.sv
// Read-side consumer of the 16-bit prefetch Fifo: pops words and replays them
// little-endian through a 4-byte ring with a valid/ready byte stream.
module fifo_byte_reader
  import prefetch_pkg::*;
#(
  parameter int unsigned BUF_BYTES = PF_BUF_BYTES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       flush_odd,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  word_t                      fifo_rd_data,
  output logic                       byte_valid,
  output byte_t                      byte_data,
  input  logic                       byte_ready,
  output logic [$clog2(BUF_BYTES):0] bytes_avail
);

  localparam int unsigned PTR_W = $clog2(BUF_BYTES);
  localparam int unsigned CNT_W = PTR_W + 1;

  byte_t              r_ring [BUF_BYTES];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_inflight;
  logic               r_drop_low;
  logic               r_byte_valid;
  byte_t              r_byte_data;

  logic               w_consume;
  logic [CNT_W-1:0]   w_count_left;
  logic [CNT_W-1:0]   w_n_app;
  byte_t              w_wr_b0;
  byte_t              w_wr_b1;
  logic [PTR_W-1:0]   w_tail_p1;
  logic [PTR_W-1:0]   w_head_nxt;
  logic [PTR_W-1:0]   w_tail_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  byte_t              w_head_byte_nxt;

  assign w_consume    = r_byte_valid & byte_ready;
  assign w_count_left = r_count - CNT_W'(w_consume);

  // Pop only with guaranteed room for a full word and no read outstanding.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (!reset && !flush && !fifo_empty && !r_inflight &&
        (w_count_left <= CNT_W'(BUF_BYTES - 2)))
      fifo_rd_en = 1'b1;
  end

  // Append/advance arithmetic; the next head byte may be one being written now.
  always_comb begin
    w_n_app   = '0;
    w_wr_b0   = fifo_rd_data[7:0];
    w_wr_b1   = fifo_rd_data[15:8];
    w_tail_p1 = r_tail + PTR_W'(1);
    if (r_inflight) begin
      if (r_drop_low) begin
        w_n_app = CNT_W'(1);
        w_wr_b0 = fifo_rd_data[15:8];
      end else begin
        w_n_app = CNT_W'(2);
      end
    end
    w_head_nxt      = r_head + PTR_W'(w_consume);
    w_tail_nxt      = r_tail + PTR_W'(w_n_app);
    w_count_nxt     = w_count_left + w_n_app;
    w_head_byte_nxt = r_ring[w_head_nxt];
    if ((w_n_app != '0) && (w_head_nxt == r_tail))
      w_head_byte_nxt = w_wr_b0;
    else if ((w_n_app == CNT_W'(2)) && (w_head_nxt == w_tail_p1))
      w_head_byte_nxt = w_wr_b1;
  end

  // Reset and flush share the discard path; only flush can arm drop_low.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_inflight   <= 1'b0;
      r_byte_valid <= 1'b0;
      r_drop_low   <= flush_odd & ~reset;
      if (reset)
        r_byte_data <= 8'h00;
    end else begin
      if (w_n_app != '0)
        r_ring[r_tail] <= w_wr_b0;
      if (w_n_app == CNT_W'(2))
        r_ring[w_tail_p1] <= w_wr_b1;
      if (r_inflight)
        r_drop_low <= 1'b0;
      r_head       <= w_head_nxt;
      r_tail       <= w_tail_nxt;
      r_count      <= w_count_nxt;
      r_inflight   <= fifo_rd_en;
      r_byte_valid <= (w_count_nxt != '0);
      if (w_count_nxt != '0)
        r_byte_data <= w_head_byte_nxt;
    end
  end

  assign byte_valid  = r_byte_valid;
  assign byte_data   = r_byte_data;
  assign bytes_avail = r_count;

endmodule
